// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - req/gnt/rvalid memory port bundle for the LSU memory stage
//
// Signals:
//   req, gnt          request / grant handshake
//   we, addr, be      write flag, XLEN/8-aligned address, byte enables
//   wdata             lane-steered store data
//   rvalid, rdata     read response
// Modports: master = LSU side, slave = memory side.
interface lsu_mem_stage_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              gnt;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - pipelined load/store memory stage with lane steering and error flags
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid / in_ready      op handshake; op fields in_is_load, in_is_nop, in_size,
//                            in_unsigned, in_imm, in_rs1_data, in_rs2_data, in_rd
//   mem (master)             req/gnt/rvalid memory port
//   wb_*                     one-cycle completion pulse with data, address and error flags
module lsu_mem_stage #(
  parameter int XLEN    = 32,
  parameter int IMM_W   = 12,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_nop,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [RD_W-1:0]   in_rd,
  lsu_mem_stage_if.master   mem,
  output logic              wb_valid,
  output logic              wb_is_load,
  output logic [RD_W-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   wb_addr,
  output logic              wb_misalign,
  output logic              wb_timeout
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] WORD_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  ea_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [RD_W-1:0]  rd_q;
  logic             is_load_q;
  logic [XLEN-1:0]  rs2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  data_q;
  logic             mis_q;
  logic             to_q;

  logic [XLEN-1:0]  imm_sext;
  logic [XLEN-1:0]  ea_in;
  logic             mis_in;
  logic             take_op;
  logic             wait_expired;
  logic [OFF_W-1:0] off;
  logic [7:0]       size_mask;
  logic [15:0]      be_wide;
  logic [XLEN-1:0]  wdata_rep;
  logic [XLEN-1:0]  rdata_shift;
  logic [XLEN-1:0]  load_ext;

  assign imm_sext     = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign ea_in        = in_rs1_data + imm_sext;
  assign take_op      = in_valid && in_ready && !in_is_nop;
  assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign off          = ea_q[OFF_W-1:0];

  // size=3 is only legal on a 64-bit datapath
  always_comb begin
    mis_in = 1'b0;
    case (in_size)
      2'd0:    mis_in = 1'b0;
      2'd1:    mis_in = ea_in[0];
      2'd2:    mis_in = |ea_in[1:0];
      default: mis_in = (XLEN == 32) || (|ea_in[2:0]);
    endcase
  end

  // Store lane steering: replicate the low bytes of rs2 across every lane so the
  // byte enables alone select where the data lands.
  always_comb begin
    size_mask = 8'h01;
    wdata_rep = rs2_q;
    case (size_q)
      2'd0: begin
        size_mask = 8'h01;
        wdata_rep = {BE_W{rs2_q[7:0]}};
      end
      2'd1: begin
        size_mask = 8'h03;
        wdata_rep = {(BE_W/2){rs2_q[15:0]}};
      end
      2'd2: begin
        size_mask = 8'h0F;
        wdata_rep = {(BE_W/4){rs2_q[31:0]}};
      end
      default: begin
        size_mask = 8'hFF;
        wdata_rep = rs2_q;
      end
    endcase
  end

  assign be_wide = {8'h00, size_mask} << off;

  // Load lane extraction: bring the addressed lane down to bit 0, then extend.
  assign rdata_shift = mem.rdata >> {off, 3'b000};

  always_comb begin
    load_ext = rdata_shift;
    case (size_q)
      2'd0: load_ext = {{(XLEN-8){!uns_q && rdata_shift[7]}}, rdata_shift[7:0]};
      2'd1: load_ext = {{(XLEN-16){!uns_q && rdata_shift[15]}}, rdata_shift[15:0]};
      2'd2: load_ext = (rdata_shift & WORD_MASK)
                     | ((!uns_q && rdata_shift[31]) ? ~WORD_MASK : '0);
      default: load_ext = rdata_shift;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (take_op) state_d = mis_in ? RESP : REQ;
      REQ:  if (mem.gnt) state_d = is_load_q ? WAIT : RESP;
      WAIT: if (mem.rvalid || wait_expired) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Op latch, wait counter and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ea_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      rs2_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_op) begin
            ea_q      <= ea_in;
            size_q    <= in_size;
            uns_q     <= in_unsigned;
            rd_q      <= in_rd;
            is_load_q <= in_is_load;
            rs2_q     <= in_rs2_data;
            mis_q     <= mis_in;
            to_q      <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
          end
        end
        WAIT: begin
          if (mem.rvalid) begin
            data_q <= load_ext;
            cnt_q  <= '0;
          end else if (wait_expired) begin
            to_q  <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready    = (state_q == IDLE) && rst_n;
    mem.req     = (state_q == REQ);
    mem.we      = mem.req && !is_load_q;
    mem.addr    = mem.req ? {ea_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    mem.be      = mem.req ? be_wide[BE_W-1:0] : '0;
    mem.wdata   = mem.req ? wdata_rep : '0;
    wb_valid    = (state_q == RESP);
    wb_is_load  = wb_valid && is_load_q;
    wb_rd       = (wb_valid && is_load_q) ? rd_q : '0;
    wb_data     = wb_valid ? data_q : '0;
    wb_addr     = wb_valid ? ea_q : '0;
    wb_misalign = wb_valid && mis_q;
    wb_timeout  = wb_valid && to_q;
  end

endmodule
